// File: rtl/camera_fifo_pkg.sv
// Shared state encoding and default geometry for the camera FIFO burst reader.
package camera_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA
  } rd_state_e;

  localparam int DEF_PIX_W     = 16;
  localparam int DEF_PACK      = 8;
  localparam int DEF_BURST_LEN = 16;

  function automatic int burst_bytes(input int pix_w, input int pack, input int burst_len);
    return burst_len * pack * pix_w / 8;
  endfunction

  localparam int DEF_BURST_BYTES = burst_bytes(DEF_PIX_W, DEF_PACK, DEF_BURST_LEN);

endpackage

// File: rtl/camera_pix_packer.sv
// Packs PACK pixels into one word (first pixel in the LSBs) behind a one-word output register.
module camera_pix_packer #(
  parameter int PIX_W = 16,
  parameter int PACK  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [PIX_W-1:0]      pix_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PIX_W*PACK-1:0] out_data
);

  localparam int CNT_W = $clog2(PACK + 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d, slot;
  logic [PIX_W*PACK-1:0] pack_q, pack_d, out_q, out_d;
  logic                  out_vld_q, out_vld_d;
  logic                  full, out_free, move, take;

  // A full pack register drains into the output register whenever it is free,
  // and in that same cycle the next pixel may already land in slot 0.
  always_comb begin
    full      = (cnt_q == CNT_W'(PACK));
    out_free  = !out_vld_q || out_ready;
    move      = full && out_free;
    pix_ready = !full || out_free;
    take      = pix_valid && pix_ready;
    pack_d    = pack_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;
    slot      = move ? '0 : cnt_q;
    if (move) begin
      out_d     = pack_q;
      out_vld_d = 1'b1;
      cnt_d     = '0;
    end else if (out_ready) begin
      out_vld_d = 1'b0;
    end
    if (take) begin
      pack_d[int'(slot)*PIX_W +: PIX_W] = pix_data;
      cnt_d = slot + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      pack_q    <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pack_q    <= pack_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_data  = out_q;

endmodule

// File: rtl/camera_fifo_burst_reader.sv
// Reads camera pixels from a prefetch FIFO and emits address-tagged write bursts of packed words.
// Optional burst statistics counter enabled by defining CAMERA_BURST_RD_STAT_EN.
module camera_fifo_burst_reader
  import camera_fifo_pkg::*;
#(
  parameter int                PIX_W       = DEF_PIX_W,
  parameter int                PACK        = DEF_PACK,
  parameter int                BURST_LEN   = DEF_BURST_LEN,
  parameter int                ADDR_W      = 28,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter logic [31:0]       FRAME_BYTES = 32'h0025_8000
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  frame_start,
  output logic                  fifo_rd_en,
  input  logic                  fifo_rd_vld,
  input  logic [PIX_W-1:0]      fifo_rd_data,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ADDR_W-1:0]     cmd_addr,
  output logic [7:0]            cmd_len,
  output logic                  dat_valid,
  input  logic                  dat_ready,
  output logic [PIX_W*PACK-1:0] dat_data,
  output logic                  dat_last,
  output logic                  busy
`ifdef CAMERA_BURST_RD_STAT_EN
  ,
  output logic [15:0]           burst_cnt
`endif
);

  localparam int                BURST_PIX = BURST_LEN * PACK;
  localparam int                POP_W     = $clog2(BURST_PIX + 1);
  localparam int                BEAT_W    = $clog2(BURST_LEN + 1);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(burst_bytes(PIX_W, PACK, BURST_LEN));
  localparam logic [ADDR_W-1:0] END_ADDR  = BASE_ADDR + ADDR_W'(FRAME_BYTES);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
  logic              pend_q, pend_d;
  logic [POP_W-1:0]  pop_cnt_q, pop_cnt_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              pop, cmd_fire, beat_fire, pk_ready;

  camera_pix_packer #(
    .PIX_W (PIX_W),
    .PACK  (PACK)
  ) u_packer (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .pix_valid (pop),
    .pix_ready (pk_ready),
    .pix_data  (fifo_rd_data),
    .out_valid (dat_valid),
    .out_ready (dat_ready),
    .out_data  (dat_data)
  );

  // addr_q always holds the address of the next command; a pending frame
  // restart only overrides it at CMD entry so an in-flight burst is untouched.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pend_d     = pend_q | frame_start;
    pop_cnt_d  = pop_cnt_q;
    beat_cnt_d = beat_cnt_q;
    addr_inc   = addr_q + STEP;
    fifo_rd_en = (state_q == ST_DATA) && (pop_cnt_q < POP_W'(BURST_PIX)) && pk_ready;
    pop        = fifo_rd_en && fifo_rd_vld;
    cmd_valid  = (state_q == ST_CMD);
    cmd_fire   = cmd_valid && cmd_ready;
    dat_last   = dat_valid && (beat_cnt_q == BEAT_W'(BURST_LEN - 1));
    beat_fire  = dat_valid && dat_ready;
    if (pop)       pop_cnt_d  = pop_cnt_q + POP_W'(1);
    if (beat_fire) beat_cnt_d = beat_cnt_q + BEAT_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (fifo_rd_vld) begin
          state_d = ST_CMD;
          if (pend_q || frame_start) begin
            addr_d = BASE_ADDR;
            pend_d = 1'b0;
          end
        end
      end
      ST_CMD: begin
        if (cmd_fire) begin
          state_d    = ST_DATA;
          addr_d     = (addr_inc == END_ADDR) ? BASE_ADDR : addr_inc;
          pop_cnt_d  = '0;
          beat_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (beat_fire && dat_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= BASE_ADDR;
      pend_q     <= 1'b0;
      pop_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pend_q     <= pend_d;
      pop_cnt_q  <= pop_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign cmd_addr = addr_q;
  assign cmd_len  = 8'(BURST_LEN - 1);
  assign busy     = (state_q != ST_IDLE);

`ifdef CAMERA_BURST_RD_STAT_EN
  logic [15:0] burst_cnt_q, burst_cnt_d;

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (frame_start)                               burst_cnt_d = '0;
    else if (cmd_fire && burst_cnt_q != 16'hFFFF)  burst_cnt_d = burst_cnt_q + 16'd1;
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) burst_cnt_q <= '0;
    else        burst_cnt_q <= burst_cnt_d;
  end

  assign burst_cnt = burst_cnt_q;
`endif

endmodule

// File: tb/tb_camera_fifo_burst_reader.sv
// Scoreboard bench for camera_fifo_burst_reader: FIFO model feeds pixels, monitor checks commands and beats.
module tb_camera_fifo_burst_reader;

  localparam int PIX_W       = 16;
  localparam int PACK        = 8;
  localparam int BURST_LEN   = 16;
  localparam int ADDR_W      = 28;
  localparam int FRAME_BYTES = 1024;
  localparam int BURST_BYTES = BURST_LEN * PACK * PIX_W / 8;
  localparam int WORD_W      = PIX_W * PACK;

  typedef logic [WORD_W-1:0] word_t;

  logic              rd_clk, rd_rst, frame_start;
  logic              fifo_rd_en, fifo_rd_vld;
  logic [PIX_W-1:0]  fifo_rd_data;
  logic              cmd_valid, cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic              dat_valid, dat_ready, dat_last, busy;
  word_t             dat_data;
`ifdef CAMERA_BURST_RD_STAT_EN
  logic [15:0]       burst_cnt;
`endif

  camera_fifo_burst_reader #(
    .PIX_W       (PIX_W),
    .PACK        (PACK),
    .BURST_LEN   (BURST_LEN),
    .ADDR_W      (ADDR_W),
    .BASE_ADDR   ('0),
    .FRAME_BYTES (32'd1024)
  ) dut (
    .rd_clk       (rd_clk),
    .rd_rst       (rd_rst),
    .frame_start  (frame_start),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_vld  (fifo_rd_vld),
    .fifo_rd_data (fifo_rd_data),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .dat_valid    (dat_valid),
    .dat_ready    (dat_ready),
    .dat_data     (dat_data),
    .dat_last     (dat_last),
    .busy         (busy)
`ifdef CAMERA_BURST_RD_STAT_EN
    ,
    .burst_cnt    (burst_cnt)
`endif
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  int          checks = 0;
  int          errors = 0;
  logic [PIX_W-1:0] fifo_q[$];
  word_t       exp_word_q[$];
  bit          exp_last_q[$];
  int          gen_pix_cnt = 0;
  int          gen_word_cnt = 0;
  word_t       gen_word = '0;
  int          model_next_addr = 0;
  bit          model_pend = 1'b0;
  bit          pop_pending = 1'b0;
  int          cyc = 0;
  int          vld_mode = 0;
  int          rdy_mode = 0;
  bit          cmd_ready_hold = 1'b1;
  int          beat_total = 0;
  int          cmd_total = 0;

  task automatic checkOutput(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Pixels go into the FIFO model; every PACK of them also forms the expected beat.
  task automatic applyStimulus(input int n, input bit incrementing, input int start);
    for (int i = 0; i < n; i++) begin
      logic [PIX_W-1:0] p;
      p = incrementing ? PIX_W'(start + i) : PIX_W'($urandom);
      fifo_q.push_back(p);
      gen_word[gen_pix_cnt*PIX_W +: PIX_W] = p;
      gen_pix_cnt++;
      if (gen_pix_cnt == PACK) begin
        exp_word_q.push_back(gen_word);
        exp_last_q.push_back((gen_word_cnt % BURST_LEN) == BURST_LEN - 1);
        gen_word_cnt++;
        gen_pix_cnt = 0;
      end
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_fifo_rd_en"}, word_t'(fifo_rd_en), '0);
    checkOutput({tag, "_cmd_valid"},  word_t'(cmd_valid),  '0);
    checkOutput({tag, "_dat_valid"},  word_t'(dat_valid),  '0);
    checkOutput({tag, "_dat_last"},   word_t'(dat_last),   '0);
    checkOutput({tag, "_busy"},       word_t'(busy),       '0);
    checkOutput({tag, "_dat_data"},   dat_data,            '0);
    checkOutput({tag, "_cmd_addr"},   word_t'(cmd_addr),   '0);
    checkOutput({tag, "_cmd_len"},    word_t'(cmd_len),    word_t'(BURST_LEN - 1));
`ifdef CAMERA_BURST_RD_STAT_EN
    checkOutput({tag, "_burst_cnt"},  word_t'(burst_cnt),  '0);
`endif
  endtask

  task automatic waitBeatsMore(input int n, input int budget, input string tag);
    int tgt;
    tgt = beat_total + n;
    for (int c = 0; c < budget; c++) begin
      @(negedge rd_clk);
      #3;
      if (beat_total >= tgt) return;
    end
    checks++;
    errors++;
    $display("[TB] FAIL %s_timeout beats=%0d required=%0d", tag, beat_total, tgt);
  endtask

  task automatic waitIdle(input int budget, input string tag);
    for (int c = 0; c < budget; c++) begin
      @(negedge rd_clk);
      #3;
      if (!busy && exp_word_q.size() == 0) return;
    end
    checks++;
    errors++;
    $display("[TB] FAIL %s_idle_timeout busy=%0b pending_beats=%0d required=0", tag, busy, exp_word_q.size());
  endtask

  // Input driver: retires the pixel popped at the previous edge, then drives new inputs.
  always @(negedge rd_clk) begin
    cyc++;
    if (pop_pending) begin
      if (fifo_q.size() > 0) fifo_q.delete(0);
      pop_pending = 1'b0;
    end
    dat_ready    = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    cmd_ready    = cmd_ready_hold;
    fifo_rd_vld  = ((vld_mode == 0) || ((cyc / 3) % 2 == 0)) && (fifo_q.size() > 0);
    fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  end

  // Monitor: observes handshakes that will complete at the coming rising edge.
  always @(negedge rd_clk) begin
    int exp_addr;
    #1;
    if (!rd_rst) begin
      pop_pending = fifo_rd_en && fifo_rd_vld;
      if (cmd_valid && cmd_ready) begin
        exp_addr = model_pend ? 0 : model_next_addr;
        checkOutput("cmd_addr", word_t'(cmd_addr), word_t'(exp_addr));
        checkOutput("cmd_len", word_t'(cmd_len), word_t'(BURST_LEN - 1));
        model_pend = 1'b0;
        model_next_addr = exp_addr + BURST_BYTES;
        if (model_next_addr == FRAME_BYTES) model_next_addr = 0;
        cmd_total++;
      end
      if (dat_valid && dat_ready) begin
        if (exp_word_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat actual=%0h required=none", dat_data);
        end else begin
          checkOutput("dat_data", dat_data, exp_word_q.pop_front());
          checkOutput("dat_last", word_t'(dat_last), word_t'(exp_last_q.pop_front()));
        end
        beat_total++;
      end
    end
  end

  initial begin
    rd_rst       = 1'b1;
    frame_start  = 1'b0;
    fifo_rd_vld  = 1'b0;
    fifo_rd_data = '0;
    cmd_ready    = 1'b0;
    dat_ready    = 1'b0;
    repeat (3) @(negedge rd_clk);
    #3;
    checkResetValues("reset");
    @(negedge rd_clk);
    rd_rst = 1'b0;

    $display("[TB] linear frame, always ready");
    applyStimulus(128, 1'b1, 0);
    waitBeatsMore(16, 2000, "linear");
    waitIdle(200, "linear");
    checkOutput("linear_cmd_count", word_t'(cmd_total), word_t'(1));

    $display("[TB] gapped FIFO, random backpressure, wrap");
    vld_mode = 1;
    rdy_mode = 1;
    applyStimulus(512, 1'b0, 0);
    waitBeatsMore(64, 6000, "gapped");
    waitIdle(500, "gapped");
    checkOutput("gapped_cmd_count", word_t'(cmd_total), word_t'(5));

    $display("[TB] frame restart mid burst");
    vld_mode = 0;
    applyStimulus(256, 1'b0, 0);
    waitBeatsMore(3, 2000, "restart");
    @(negedge rd_clk);
    frame_start = 1'b1;
    model_pend  = 1'b1;
    @(negedge rd_clk);
    frame_start = 1'b0;
    waitBeatsMore(29, 3000, "restart");
    waitIdle(500, "restart");

    $display("[TB] command backpressure");
    rdy_mode = 0;
    cmd_ready_hold = 1'b0;
    applyStimulus(128, 1'b0, 0);
    for (int c = 0; c < 50 && !cmd_valid; c++) begin
      @(negedge rd_clk);
      #3;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge rd_clk);
      #3;
      checkOutput("stall_cmd_valid", word_t'(cmd_valid), word_t'(1));
      checkOutput("stall_cmd_addr", word_t'(cmd_addr), word_t'(model_next_addr));
      checkOutput("stall_fifo_rd_en", word_t'(fifo_rd_en), '0);
    end
    cmd_ready_hold = 1'b1;
    waitBeatsMore(16, 2000, "stall");
    waitIdle(200, "stall");

    $display("[TB] reset mid burst");
    applyStimulus(128, 1'b0, 0);
    waitBeatsMore(5, 2000, "midreset");
    rd_rst = 1'b1;
    fifo_q.delete();
    exp_word_q.delete();
    exp_last_q.delete();
    gen_pix_cnt     = 0;
    gen_word_cnt    = 0;
    pop_pending     = 1'b0;
    model_next_addr = 0;
    model_pend      = 1'b0;
    @(posedge rd_clk);
    #1;
    checkResetValues("midreset");
    @(negedge rd_clk);
    rd_rst = 1'b0;
    applyStimulus(128, 1'b1, 1000);
    waitBeatsMore(16, 2000, "post_reset");
    waitIdle(200, "post_reset");

    checkOutput("leftover_beats", word_t'(exp_word_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/camera_fifo_burst_reader.md
CAMERA_FIFO_BURST_READER -- requirements
Module: camera_fifo_burst_reader

Interface
REQ-001 Parameters SHALL be: PIX_W, 16, pixel width; PACK, 8, pixels per output word; BURST_LEN, 16, words per burst; ADDR_W, 28, byte-address width; BASE_ADDR, 0, frame buffer base; FRAME_BYTES, 32'h0025_8000, frame buffer size (multiple of burst bytes).
REQ-002 rd_clk  in  1  sole clock; all logic rising-edge.
REQ-003 rd_rst  in  1  asynchronous, active-high reset.
REQ-004 frame_start  in  1  one-cycle pulse; restart addressing at BASE_ADDR.
REQ-005 fifo_rd_en  out  1  pop request to the prefetch camera FIFO.
REQ-006 fifo_rd_vld  in  1  FIFO head pixel valid.
REQ-007 fifo_rd_data  in  PIX_W  FIFO head pixel.
REQ-008 cmd_valid / cmd_ready  out / in  1 / 1  burst command handshake.
REQ-009 cmd_addr  out  ADDR_W  burst start byte address; cmd_len  out  8  BURST_LEN-1.
REQ-010 dat_valid / dat_ready  out / in  1 / 1  data beat handshake.
REQ-011 dat_data  out  PIX_W*PACK  packed word; dat_last  out  1  final beat of burst.
REQ-012 busy  out  1  high whenever state is not IDLE.

Function
REQ-013 A pixel SHALL be popped exactly in cycles where fifo_rd_en and fifo_rd_vld are both high; fifo_rd_data is sampled in that cycle.
REQ-014 States SHALL be IDLE, CMD, DATA; IDLE->CMD when fifo_rd_vld=1; CMD->DATA on cmd_valid&cmd_ready; DATA->IDLE on dat_valid&dat_ready&dat_last.
REQ-015 cmd_valid SHALL be high only in CMD; cmd_addr and cmd_len SHALL be stable while cmd_valid is high and unaccepted.
REQ-016 In DATA, pixels SHALL fill a pack register, first pixel in bits [PIX_W-1:0], pixel k in bits [k*PIX_W +: PIX_W].
REQ-017 fifo_rd_en SHALL be high only in DATA, only while fewer than BURST_LEN*PACK pixels of the current burst have been popped, and not when the pack register is full and the output register is occupied and not being accepted.
REQ-018 A completed pack word SHALL move to the output register (dat_valid=1) on the cycle after its PACK-th pop, or on the cycle the previous beat is accepted; throughput one beat per PACK pops.
REQ-019 dat_data/dat_valid/dat_last SHALL hold until dat_ready; FIFO empty mid-burst SHALL stall without dropping or duplicating pixels.
REQ-020 dat_last SHALL be high on exactly the BURST_LEN-th beat of each burst.
REQ-021 After each accepted command, the next address SHALL be cmd_addr + BURST_LEN*PACK*PIX_W/8; if that equals BASE_ADDR+FRAME_BYTES it SHALL wrap to BASE_ADDR.
REQ-022 frame_start SHALL set a pending flag; applied (next address := BASE_ADDR, flag cleared) on entry to CMD; frame_start coinciding with wrap yields BASE_ADDR; a burst in progress SHALL complete unchanged.

Reset
REQ-023 On rd_rst: state IDLE, next address BASE_ADDR, pending flag, pixel/beat counters and pack register 0; fifo_rd_en, cmd_valid, dat_valid, dat_last, busy 0; dat_data 0; cmd_addr BASE_ADDR; cmd_len BURST_LEN-1.
REQ-024 Reset asserted mid-burst SHALL abandon the burst; popped pixels are discarded.

Configuration
REQ-025 With macro CAMERA_BURST_RD_STAT_EN defined, output burst_cnt (16 bits) SHALL count accepted bursts since reset, clear on frame_start, saturate at 16'hFFFF; without it the port and counter SHALL not exist.

Structure
REQ-026 A shared package camera_fifo_pkg SHALL hold the state enumeration, default PIX_W/PACK/BURST_LEN and the burst-bytes constant.
REQ-027 Packing SHALL be one sub-module camera_pix_packer (pixel in, packed word out, valid/ready); FSM and address logic stay in the top.

Verification
REQ-028 FIFO holds 128 pixels 0..127, ready always 1 -> one command at addr 0, cmd_len 8'd15, 16 beats, beat0 = 16'h0007..16'h0000 MSB to LSB, dat_last on beat 15.
REQ-029 fifo_rd_vld toggles every 3 cycles, dat_ready random 50% -> data order intact, no loss or duplication across 4 bursts.
REQ-030 FRAME_BYTES=1024, 5 bursts -> addresses 0,256,512,768,0.
REQ-031 frame_start during burst at addr 256 -> burst completes, next cmd_addr 0.
REQ-032 cmd_ready held 0 for 20 cycles -> cmd_addr stable, fifo_rd_en 0 throughout.
REQ-033 rd_rst asserted at beat 5 -> all outputs at reset values next edge; following burst starts at BASE_ADDR; with CAMERA_BURST_RD_STAT_EN, burst_cnt=0.
